// File: rtl/mult_stall_controller.sv
// mult_stall_controller
//   Stall sequencer for the fixed-latency EX-stage multiplier. While a
//   multiply is in flight it holds the instruction in ID/EX, freezes PC and
//   IF/ID, and inserts bubbles into EX/MEM until the product is valid. It
//   also detects load-use hazards, which makes it the single source of the
//   PC / IF_ID / ID_EX write enables.
//
// Parameters
//   MULT_LATENCY        total EX cycles a multiply occupies (>= 2)
//
// Ports
//   clk                 core clock, all state on the rising edge
//   arst                asynchronous reset, active-high
//   flush_EX            branch/jump flush of EX, aborts a multiply
//   mul_ID_EX           instruction in ID/EX is a multiply
//   mem_read_ID_EX      instruction in ID/EX is a load
//   rd_ID_EX            destination register of the ID/EX instruction
//   rs1_IF_ID           source 1 of the IF/ID instruction
//   rs2_IF_ID           source 2 of the IF/ID instruction
//   mult_start          one-cycle start pulse to the multiplier
//   mult_result_valid   product valid, EX/MEM selects multiplier result
//   mult_busy           sequencer is not idle
//   PC_write_enable     1 = PC updates
//   IF_ID_write_enable  1 = IF/ID updates
//   ID_EX_write_enable  0 = hold ID/EX contents
//   mux_control_EX      0 = inject bubble into ID/EX
//   ex_mem_bubble       1 = inject bubble into EX/MEM

module mult_stall_controller #(
    parameter int MULT_LATENCY = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       flush_EX,
    input  logic       mul_ID_EX,
    input  logic       mem_read_ID_EX,
    input  logic [4:0] rd_ID_EX,
    input  logic [4:0] rs1_IF_ID,
    input  logic [4:0] rs2_IF_ID,
    output logic       mult_start,
    output logic       mult_result_valid,
    output logic       mult_busy,
    output logic       PC_write_enable,
    output logic       IF_ID_write_enable,
    output logic       ID_EX_write_enable,
    output logic       mux_control_EX,
    output logic       ex_mem_bubble
);

    localparam int CNT_W = $clog2(MULT_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mult_stall;
    logic             load_use;

    // Next-state logic. A flush aborts in any state; the start cycle in IDLE
    // counts as the first EX cycle, so BUSY only exists for latencies above 2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_EX) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mul_ID_EX) begin
                        if (MULT_LATENCY > 2) begin
                            state_d = BUSY;
                            cnt_d   = CNT_ONE;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // The multiply still sitting in ID/EX is the one just
                    // completed, so mul_ID_EX is not a new request here.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and cycle counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hazard decode and pipeline controls. A multiply stall holds ID/EX and
    // bubbles EX/MEM; a load-use stall instead lets ID/EX take a bubble via
    // mux_control_EX. The multiply stall wins if both were ever to coincide.
    always_comb begin
        mult_start        = 1'b0;
        mult_result_valid = 1'b0;
        mult_stall        = 1'b0;
        if (!flush_EX) begin
            unique case (state_q)
                IDLE: begin
                    mult_start = mul_ID_EX;
                    mult_stall = mul_ID_EX;
                end
                BUSY:    mult_stall        = 1'b1;
                DONE:    mult_result_valid = 1'b1;
                default: mult_stall        = 1'b0;
            endcase
        end

        load_use = mem_read_ID_EX && (rd_ID_EX != 5'd0) &&
                   ((rd_ID_EX == rs1_IF_ID) || (rd_ID_EX == rs2_IF_ID));

        mult_busy          = (state_q != IDLE);
        PC_write_enable    = 1'b1;
        IF_ID_write_enable = 1'b1;
        ID_EX_write_enable = 1'b1;
        mux_control_EX     = 1'b1;
        ex_mem_bubble      = 1'b0;
        if (mult_stall) begin
            PC_write_enable    = 1'b0;
            IF_ID_write_enable = 1'b0;
            ID_EX_write_enable = 1'b0;
            ex_mem_bubble      = 1'b1;
        end else if (load_use) begin
            PC_write_enable    = 1'b0;
            IF_ID_write_enable = 1'b0;
            mux_control_EX     = 1'b0;
        end
    end

endmodule
